// File: rtl/mem_io_bridge.sv
// Memory and I/O back end for core: block RAM plus a small I/O page (TX FIFO, RX holding register, timer, LEDs).
// Define MEM_IO_TIMER_EN to build the free-running timer at 0x8003; otherwise that address reads 0.
module mem_io_bridge #(
  parameter int    RAM_ADDR_W    = 12,
  parameter int    TX_DEPTH_LOG2 = 3,
  parameter string INIT_FILE     = ""
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic [15:0] i_read_addr,
  output logic [15:0] o_read_data,
  input  logic [15:0] i_write_addr,
  input  logic [15:0] i_write_data,
  input  logic        i_write_strobe,
  output logic [7:0]  o_tx_data,
  output logic        o_tx_valid,
  input  logic        i_tx_ready,
  input  logic [7:0]  i_rx_data,
  input  logic        i_rx_valid,
  output logic        o_rx_ready,
  output logic [7:0]  o_led
);

  localparam int TX_DEPTH = 1 << TX_DEPTH_LOG2;
  localparam logic [15:0] ADDR_TX_DATA = 16'h8000;
  localparam logic [15:0] ADDR_TX_STAT = 16'h8001;
  localparam logic [15:0] ADDR_RX_DATA = 16'h8002;
  localparam logic [15:0] ADDR_TIMER   = 16'h8003;
  localparam logic [15:0] ADDR_LED     = 16'h8004;
  localparam logic [TX_DEPTH_LOG2:0]   TX_COUNT_ONE = (TX_DEPTH_LOG2+1)'(1);
  localparam logic [TX_DEPTH_LOG2-1:0] TX_PTR_ONE   = (TX_DEPTH_LOG2)'(1);

  logic [15:0] r_ram [0:(1<<RAM_ADDR_W)-1];
  logic [15:0] r_ramQ;
  logic        r_selRam;
  logic [15:0] r_ioQ;
  logic [15:0] w_ioData;

  logic [7:0]               r_txMem [0:TX_DEPTH-1];
  logic [TX_DEPTH_LOG2-1:0] r_txRd;
  logic [TX_DEPTH_LOG2-1:0] r_txWr;
  logic [TX_DEPTH_LOG2:0]   r_txCount;
  logic                     r_txOverflow;
  logic                     w_txFull;
  logic                     w_txEmpty;
  logic                     w_txPush;
  logic                     w_txPop;
  logic [3:0]               w_txCountField;

  logic       r_rxFull;
  logic [7:0] r_rxByte;
  logic [7:0] r_led;

  logic w_wrRam;
  logic w_wrTx;
  logic w_wrTxStat;
  logic w_wrLed;
  logic w_rdRx;

  assign w_wrRam    = i_write_strobe && !i_write_addr[15];
  assign w_wrTx     = i_write_strobe && (i_write_addr == ADDR_TX_DATA);
  assign w_wrTxStat = i_write_strobe && (i_write_addr == ADDR_TX_STAT);
  assign w_wrLed    = i_write_strobe && (i_write_addr == ADDR_LED);
  assign w_rdRx     = (i_read_addr == ADDR_RX_DATA);

  // No reset here so the array and its output register map onto block RAM; NBA gives read-before-write.
  always_ff @(posedge i_clk) begin
    if (w_wrRam) r_ram[i_write_addr[RAM_ADDR_W-1:0]] <= i_write_data;
    r_ramQ <= r_ram[i_read_addr[RAM_ADDR_W-1:0]];
  end

  assign w_txFull       = r_txCount[TX_DEPTH_LOG2];
  assign w_txEmpty      = (r_txCount == '0);
  assign w_txPush       = w_wrTx && !w_txFull;
  assign w_txPop        = o_tx_valid && i_tx_ready;
  assign w_txCountField = 4'(r_txCount);
  assign o_tx_valid     = !w_txEmpty;
  assign o_tx_data      = r_txMem[r_txRd];

  always_ff @(posedge i_clk) begin
    if (w_txPush && !i_reset) r_txMem[r_txWr] <= i_write_data[7:0];
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_txRd       <= '0;
      r_txWr       <= '0;
      r_txCount    <= '0;
      r_txOverflow <= 1'b0;
    end else begin
      if (w_txPush) r_txWr <= r_txWr + TX_PTR_ONE;
      if (w_txPop)  r_txRd <= r_txRd + TX_PTR_ONE;
      case ({w_txPush, w_txPop})
        2'b10:   r_txCount <= r_txCount + TX_COUNT_ONE;
        2'b01:   r_txCount <= r_txCount - TX_COUNT_ONE;
        default: r_txCount <= r_txCount;
      endcase
      if (w_wrTx && w_txFull) r_txOverflow <= 1'b1;
      else if (w_wrTxStat)    r_txOverflow <= 1'b0;
    end
  end

  assign o_rx_ready = !r_rxFull && !i_reset;
  assign o_led      = r_led;

  // Reading RX_DATA while full hands the byte to the core and empties the holding register.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_rxFull <= 1'b0;
      r_rxByte <= 8'h00;
      r_led    <= 8'h00;
    end else begin
      if (w_rdRx && r_rxFull) begin
        r_rxFull <= 1'b0;
        r_rxByte <= 8'h00;
      end else if (i_rx_valid && o_rx_ready) begin
        r_rxFull <= 1'b1;
        r_rxByte <= i_rx_data;
      end
      if (w_wrLed) r_led <= i_write_data[7:0];
    end
  end

`ifdef MEM_IO_TIMER_EN
  logic [15:0] r_timer;

  always_ff @(posedge i_clk) begin
    if (i_reset)                                          r_timer <= 16'h0000;
    else if (i_write_strobe && i_write_addr == ADDR_TIMER) r_timer <= i_write_data;
    else                                                  r_timer <= r_timer + 16'h0001;
  end
`endif

  // Status layout: bit7 overflow, bit6 zero, bits5:2 count, bit1 empty, bit0 full.
  always_comb begin
    w_ioData = 16'h0000;
    case (i_read_addr)
      ADDR_TX_STAT: w_ioData = {8'h00, r_txOverflow, 1'b0, w_txCountField, w_txEmpty, w_txFull};
      ADDR_RX_DATA: w_ioData = {7'b0, r_rxFull, r_rxByte};
`ifdef MEM_IO_TIMER_EN
      ADDR_TIMER:   w_ioData = r_timer;
`endif
      ADDR_LED:     w_ioData = {8'h00, r_led};
      default:      w_ioData = 16'h0000;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_selRam <= 1'b0;
      r_ioQ    <= 16'hF000;
    end else begin
      r_selRam <= !i_read_addr[15];
      r_ioQ    <= w_ioData;
    end
  end

  assign o_read_data = r_selRam ? r_ramQ : r_ioQ;

endmodule

// File: tb/tb_mem_io_bridge.sv
// Self-checking bench for mem_io_bridge: directed scenarios followed by randomized traffic against a queue/array model.
// Define MEM_IO_TIMER_EN for both bench and RTL to exercise the timer build.
module tb_mem_io_bridge;

  localparam int TXD = 8;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] readAddr;
  logic [15:0] writeAddr;
  logic [15:0] writeData;
  logic        writeStrobe;
  logic        txReady;
  logic [7:0]  rxData;
  logic        rxValid;
  logic [15:0] o_read_data;
  logic [7:0]  o_tx_data;
  logic        o_tx_valid;
  logic        o_rx_ready;
  logic [7:0]  o_led;

  int testCount = 0;
  int failCount = 0;

  logic [15:0] mRam [0:4095];
  bit          mKnown [0:4095];
  logic [7:0]  mTx [$];
  bit          mOvf;
  bit          mRxFull;
  logic [7:0]  mRxByte;
  logic [7:0]  mLed;
`ifdef MEM_IO_TIMER_EN
  logic [15:0] mTimer;
`endif

  always #5 clk = ~clk;

  mem_io_bridge dut (
    .i_clk          (clk),
    .i_reset        (reset),
    .i_read_addr    (readAddr),
    .o_read_data    (o_read_data),
    .i_write_addr   (writeAddr),
    .i_write_data   (writeData),
    .i_write_strobe (writeStrobe),
    .o_tx_data      (o_tx_data),
    .o_tx_valid     (o_tx_valid),
    .i_tx_ready     (txReady),
    .i_rx_data      (rxData),
    .i_rx_valid     (rxValid),
    .o_rx_ready     (o_rx_ready),
    .o_led          (o_led)
  );

  task automatic checkOutput(input string tag, input logic [15:0] observed, input logic [15:0] expected);
    testCount++;
    assert (observed === expected) else begin
      failCount++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  function automatic logic [15:0] modelRead(input logic [15:0] a);
    int status;
    if (!a[15]) return mRam[a[11:0]];
    case (a)
      16'h8001: begin
        status = (mOvf ? 128 : 0) + mTx.size() * 4 + (mTx.size() == 0 ? 2 : 0) + (mTx.size() == TXD ? 1 : 0);
        return 16'(status);
      end
      16'h8002: return mRxFull ? (16'h0100 | 16'(mRxByte)) : 16'h0000;
`ifdef MEM_IO_TIMER_EN
      16'h8003: return mTimer;
`endif
      16'h8004: return 16'(mLed);
      default:  return 16'h0000;
    endcase
  endfunction

  function automatic bit modelKnown(input logic [15:0] a);
    return a[15] || mKnown[a[11:0]];
  endfunction

  // One clock: predict the read data from pre-edge state, advance the model, then compare after the edge.
  task automatic applyStimulus(input string tag);
    logic [15:0] expRead;
    bit          expKnown;
    bit          full0;
    bit          rxFull0;
    if (reset) begin
      expRead  = 16'hF000;
      expKnown = 1'b1;
      mTx.delete();
      mOvf    = 1'b0;
      mRxFull = 1'b0;
      mRxByte = 8'h00;
      mLed    = 8'h00;
`ifdef MEM_IO_TIMER_EN
      mTimer  = 16'h0000;
`endif
    end else begin
      expRead  = modelRead(readAddr);
      expKnown = modelKnown(readAddr);
      full0    = (mTx.size() == TXD);
      rxFull0  = mRxFull;
      if (txReady && mTx.size() > 0) void'(mTx.pop_front());
      if (readAddr == 16'h8002 && rxFull0) begin
        mRxFull = 1'b0;
        mRxByte = 8'h00;
      end else if (rxValid && !rxFull0) begin
        mRxFull = 1'b1;
        mRxByte = rxData;
      end
`ifdef MEM_IO_TIMER_EN
      mTimer = mTimer + 16'd1;
`endif
      if (writeStrobe) begin
        if (!writeAddr[15]) begin
          mRam[writeAddr[11:0]]   = writeData;
          mKnown[writeAddr[11:0]] = 1'b1;
        end else begin
          case (writeAddr)
            16'h8000: if (full0) mOvf = 1'b1; else mTx.push_back(writeData[7:0]);
            16'h8001: mOvf = 1'b0;
`ifdef MEM_IO_TIMER_EN
            16'h8003: mTimer = writeData;
`endif
            16'h8004: mLed = writeData[7:0];
            default: ;
          endcase
        end
      end
    end
    @(posedge clk);
    #1;
    if (expKnown) checkOutput({tag, ":read"}, o_read_data, expRead);
    checkOutput({tag, ":txValid"}, 16'(o_tx_valid), 16'(mTx.size() > 0));
    if (mTx.size() > 0) checkOutput({tag, ":txData"}, 16'(o_tx_data), 16'(mTx[0]));
    checkOutput({tag, ":rxReady"}, 16'(o_rx_ready), 16'(!reset && !mRxFull));
    checkOutput({tag, ":led"}, 16'(o_led), 16'(mLed));
  endtask

  task automatic cycle(input string tag, input logic [15:0] ra, input logic ws,
                       input logic [15:0] wa, input logic [15:0] wd);
    readAddr    = ra;
    writeStrobe = ws;
    writeAddr   = wa;
    writeData   = wd;
    applyStimulus(tag);
  endtask

  function automatic logic [15:0] randAddr();
    int k;
    k = $urandom_range(0, 9);
    if (k < 6) return 16'(($urandom_range(0, 7) << 12) | $urandom_range(0, 63));
    else if (k < 9) return 16'h8000 + 16'($urandom_range(0, 5));
    else return 16'hFFFF;
  endfunction

  initial begin
    for (int i = 0; i < 4096; i++) mKnown[i] = 1'b0;
    reset       = 1'b1;
    readAddr    = 16'h0000;
    writeAddr   = 16'h0000;
    writeData   = 16'h0000;
    writeStrobe = 1'b0;
    txReady     = 1'b0;
    rxData      = 8'h00;
    rxValid     = 1'b0;

    for (int i = 0; i < 3; i++) cycle("reset", 16'h0000, 1'b0, 16'h0000, 16'h0000);
    checkOutput("reset_read_nop", o_read_data, 16'hF000);
    checkOutput("reset_tx_valid", 16'(o_tx_valid), 16'h0000);
    checkOutput("reset_rx_ready", 16'(o_rx_ready), 16'h0000);
    checkOutput("reset_led", 16'(o_led), 16'h0000);
    reset = 1'b0;
    #1;
    checkOutput("rx_ready_after_reset", 16'(o_rx_ready), 16'h0001);
    checkOutput("first_read_data", o_read_data, 16'hF000);

    cycle("ram_wr", 16'h8FFF, 1'b1, 16'h0010, 16'h1234);
    cycle("ram_rd", 16'h0010, 1'b0, 16'h0000, 16'h0000);
    checkOutput("ram_0010", o_read_data, 16'h1234);

    cycle("tx_push41", 16'h8FFF, 1'b1, 16'h8000, 16'h0041);
    cycle("tx_push42", 16'h8FFF, 1'b1, 16'h8000, 16'h0042);
    cycle("tx_stat", 16'h8001, 1'b0, 16'h0000, 16'h0000);
    checkOutput("tx_status_two", o_read_data, 16'h0008);
    checkOutput("tx_head_41", 16'(o_tx_data), 16'h0041);
    txReady = 1'b1;
    cycle("tx_pop1", 16'h8FFF, 1'b0, 16'h0000, 16'h0000);
    checkOutput("tx_head_42", 16'(o_tx_data), 16'h0042);
    cycle("tx_pop2", 16'h8FFF, 1'b0, 16'h0000, 16'h0000);
    checkOutput("tx_drained", 16'(o_tx_valid), 16'h0000);

    txReady = 1'b0;
    for (int i = 1; i <= 9; i++) cycle("tx_fill", 16'h8FFF, 1'b1, 16'h8000, 16'(i));
    cycle("tx_ovf_stat", 16'h8001, 1'b0, 16'h0000, 16'h0000);
    checkOutput("tx_overflow_full", o_read_data, 16'h00A1);
    cycle("tx_ovf_clr", 16'h8FFF, 1'b1, 16'h8001, 16'h0000);
    cycle("tx_clr_stat", 16'h8001, 1'b0, 16'h0000, 16'h0000);
    checkOutput("tx_overflow_cleared", o_read_data, 16'h0021);
    txReady = 1'b1;
    for (int i = 0; i < 8; i++) cycle("tx_drain", 16'h8FFF, 1'b0, 16'h0000, 16'h0000);
    checkOutput("tx_drain_empty", 16'(o_tx_valid), 16'h0000);
    txReady = 1'b0;

    rxData  = 8'h5A;
    rxValid = 1'b1;
    cycle("rx_capture", 16'h8FFF, 1'b0, 16'h0000, 16'h0000);
    checkOutput("rx_ready_low", 16'(o_rx_ready), 16'h0000);
    rxValid = 1'b0;
    cycle("rx_read1", 16'h8002, 1'b0, 16'h0000, 16'h0000);
    checkOutput("rx_read_full", o_read_data, 16'h015A);
    checkOutput("rx_ready_back", 16'(o_rx_ready), 16'h0001);
    cycle("rx_read2", 16'h8002, 1'b0, 16'h0000, 16'h0000);
    checkOutput("rx_read_empty", o_read_data, 16'h0000);

    cycle("tmr_load", 16'h8FFF, 1'b1, 16'h8003, 16'hFFFE);
    cycle("tmr_rd0", 16'h8003, 1'b0, 16'h0000, 16'h0000);
`ifdef MEM_IO_TIMER_EN
    checkOutput("timer_fffe", o_read_data, 16'hFFFE);
`else
    checkOutput("timer_off0", o_read_data, 16'h0000);
`endif
    cycle("tmr_rd1", 16'h8003, 1'b0, 16'h0000, 16'h0000);
`ifdef MEM_IO_TIMER_EN
    checkOutput("timer_ffff", o_read_data, 16'hFFFF);
`else
    checkOutput("timer_off1", o_read_data, 16'h0000);
`endif
    cycle("tmr_rd2", 16'h8003, 1'b0, 16'h0000, 16'h0000);
    checkOutput("timer_wrap", o_read_data, 16'h0000);

    cycle("led_wr", 16'h8FFF, 1'b1, 16'h8004, 16'hABC5);
    cycle("led_rd", 16'h8004, 1'b0, 16'h0000, 16'h0000);
    checkOutput("led_read", o_read_data, 16'h00C5);

    cycle("rbw_init", 16'h8FFF, 1'b1, 16'h0020, 16'h1111);
    cycle("rbw_same", 16'h0020, 1'b1, 16'h0020, 16'h2222);
    checkOutput("rbw_old", o_read_data, 16'h1111);
    cycle("rbw_next", 16'h0020, 1'b0, 16'h0000, 16'h0000);
    checkOutput("rbw_new", o_read_data, 16'h2222);
    cycle("alias_rd", 16'h5020, 1'b0, 16'h0000, 16'h0000);
    checkOutput("ram_alias", o_read_data, 16'h2222);

    for (int i = 0; i < 64; i++) cycle("fill", 16'h8FFF, 1'b1, 16'(i), 16'($urandom));

    for (int i = 0; i < 400; i++) begin
      reset   = (i == 200 || i == 201);
      txReady = 1'($urandom_range(0, 1));
      rxValid = 1'($urandom_range(0, 1));
      rxData  = 8'($urandom);
      cycle("rand", randAddr(), !reset && ($urandom_range(0, 2) == 0), randAddr(), 16'($urandom));
    end
    reset = 1'b0;

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
